// File: rtl/posit_pkg.sv
// posit_pkg: shared posit types, default sizes and special encodings
package posit_pkg;
    localparam int P_N  = 32;
    localparam int P_ES = 2;
    localparam int P_FW = 2*P_N;
    localparam int P_RS = $clog2(P_N);

    typedef enum logic [1:0] {RNE = 2'b00, RTZ = 2'b01, RUP = 2'b10, RDN = 2'b11} rmode_e;

    typedef struct packed {
        logic                   sign;
        logic signed [P_RS+1:0] k;
        logic [P_ES-1:0]        exp;
        logic [P_FW-1:0]        frac;
        logic                   sticky;
        logic                   zero;
        logic                   nar;
    } posit_unpacked_t;

    // Encodings are returned 64 bits wide; callers slice to their width.
    function automatic logic [63:0] maxpos(input int n);
        return (64'd1 << (n-1)) - 64'd1;
    endfunction

    function automatic logic [63:0] minpos(input int n);
        return (n > 1) ? 64'd1 : 64'd0;
    endfunction

    function automatic logic [63:0] nar(input int n);
        return 64'd1 << (n-1);
    endfunction
endpackage

// File: rtl/posit_regime_enc.sv
// posit_regime_enc: regime value k to left-aligned regime pattern and its bit length
module posit_regime_enc #(
    parameter int N  = 32,
    parameter int RS = $clog2(N)
) (
    input  logic signed [RS+1:0] k,
    output logic [N-2:0]         regime,
    output logic [RS-1:0]        rlen
);
    localparam int KW = RS + 2;
    // Out-of-range k saturates downstream; clamping keeps the pattern within N-1 bits.
    localparam logic signed [RS+1:0] K_MAX = KW'(N-3);
    localparam logic signed [RS+1:0] K_MIN = KW'(-(N-2));
    logic signed [RS+1:0] kc;
    logic [RS+1:0]        run;
    always_comb begin
        kc     = (k > K_MAX) ? K_MAX : (k < K_MIN) ? K_MIN : k;
        run    = kc[RS+1] ? -kc : kc + 1'b1;
        regime = kc[RS+1] ? ({1'b1, {(N-2){1'b0}}} >> run) : ~({(N-1){1'b1}} >> run);
        rlen   = RS'(run + 1'b1);
    end
endmodule

// File: rtl/posit_round_pipe.sv
// posit_round_pipe: two-stage posit encode/round/saturate pipeline with valid/ready
module posit_round_pipe
    import posit_pkg::*;
#(
    parameter int N  = 32,
    parameter int ES = 2,
    parameter int FW = 2*N,
    parameter int RS = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic signed [RS+1:0] in_k,
    input  logic [ES-1:0]        in_exp,
    input  logic [FW-1:0]        in_frac,
    input  logic                 in_sticky,
    input  logic                 in_zero,
    input  logic                 in_nar,
    input  logic [1:0]           in_rmode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_posit,
    output logic                 out_inexact,
    output logic                 out_sat
);
    localparam int W  = N + ES + FW;
    localparam int KW = RS + 2;
    localparam logic signed [RS+1:0] K_HI = KW'(N-2);
    localparam logic signed [RS+1:0] K_LO = KW'(-(N-1));
    localparam logic [63:0] MAXP = maxpos(N);
    localparam logic [63:0] MINP = minpos(N);
    localparam logic [63:0] NARV = nar(N);

    logic          advance;
    logic [N-2:0]  regime;
    logic [RS-1:0] rlen;
    logic [W-1:0]  body_w;
    logic          v1, s1_sign, s1_l, s1_g, s1_s, s1_zero, s1_nar, s1_hi, s1_lo;
    logic [N-2:0]  s1_body;
    rmode_e        s1_rmode;
    logic          inc, range_sat, sat_d, inexact_d, special;
    logic [N-1:0]  mag_c, posit_d;
    logic [N-2:0]  mag;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    posit_regime_enc #(.N(N), .RS(RS)) u_regime (
        .k      (in_k),
        .regime (regime),
        .rlen   (rlen)
    );

    // exp/frac slide right past the regime, which is then laid over the top bits
    assign body_w = ({in_exp, in_frac, {N{1'b0}}} >> rlen) | {regime, {(W-N+1){1'b0}}};

    always_comb begin
        inc = (s1_rmode == RNE) ? s1_g & (s1_s | s1_l)
            : (s1_rmode == RUP) ? ~s1_sign & (s1_g | s1_s)
            : (s1_rmode == RDN) ? s1_sign & (s1_g | s1_s)
            : 1'b0;
        mag_c     = {1'b0, s1_body} + {{(N-1){1'b0}}, inc};
        range_sat = s1_hi | s1_lo | ~|mag_c;
        mag       = (s1_hi | mag_c[N-1]) ? MAXP[N-2:0]
                  : (s1_lo | ~|mag_c)    ? MINP[N-2:0]
                  : mag_c[N-2:0];
        special   = s1_nar | s1_zero;
        posit_d   = s1_nar ? NARV[N-1:0] : s1_zero ? '0
                  : s1_sign ? -{1'b0, mag} : {1'b0, mag};
        sat_d     = ~special & (range_sat | mag_c[N-1]);
        inexact_d = ~special & (s1_g | s1_s | range_sat);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1          <= 1'b0;
            out_valid   <= 1'b0;
            out_posit   <= '0;
            out_inexact <= 1'b0;
            out_sat     <= 1'b0;
        end else if (advance) begin
            v1        <= in_valid;
            out_valid <= v1;
            if (in_valid) begin
                s1_sign  <= in_sign;
                s1_body  <= body_w[W-1 -: N-1];
                s1_l     <= body_w[W-N+1];
                s1_g     <= body_w[W-N];
                s1_s     <= |body_w[W-N-1:0] | in_sticky;
                s1_hi    <= in_k >= K_HI;
                s1_lo    <= in_k <= K_LO;
                s1_zero  <= in_zero;
                s1_nar   <= in_nar;
                s1_rmode <= rmode_e'(in_rmode);
            end
            if (v1) begin
                out_posit   <= posit_d;
                out_inexact <= inexact_d;
                out_sat     <= sat_d;
            end
        end
    end
endmodule

// File: tb/tb_posit_round_pipe.sv
// tb_posit_round_pipe: directed and randomized checks of posit_round_pipe against a bit-list model
module tb_posit_round_pipe;
    import posit_pkg::*;
    localparam int N = 32, ES = 2, FW = 64, RS = 5;

    typedef struct packed {
        posit_unpacked_t u;
        logic [1:0]      rm;
    } beat_t;

    typedef struct {
        logic [N-1:0] posit;
        logic         inexact;
        logic         sat;
        logic         has_lit;
        logic [N+1:0] lit;
    } exp_t;

    logic clk = 0, rst = 1;
    logic in_valid = 0, in_ready, in_sign = 0, in_sticky = 0, in_zero = 0, in_nar = 0;
    logic signed [RS+1:0] in_k = '0;
    logic [ES-1:0] in_exp = '0;
    logic [FW-1:0] in_frac = '0;
    logic [1:0] in_rmode = '0;
    logic out_valid, out_ready, out_inexact, out_sat;
    logic [N-1:0] out_posit;
    logic rdy_rand = 0, rdy_val = 1, saw_low = 0;
    int n_checks = 0, n_errors = 0, popped = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_stall = 0, prev_inex, prev_sat;
    logic [N-1:0] prev_posit;

    always #5 clk = ~clk;

    posit_round_pipe #(.N(N), .ES(ES), .FW(FW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_k(in_k), .in_exp(in_exp), .in_frac(in_frac),
        .in_sticky(in_sticky), .in_zero(in_zero), .in_nar(in_nar), .in_rmode(in_rmode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_posit(out_posit), .out_inexact(out_inexact), .out_sat(out_sat)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference: lay the posit out bit by bit, cut at N-1, round on the integer value.
    function automatic exp_t model(input beat_t b);
        exp_t e = '{default: '0};
        bit bits[$];
        longint kept;
        longint maxv = (longint'(1) << (N-1)) - 1;
        bit g, s, up;
        int k = int'(b.u.k);
        logic [N-2:0] mag;
        if (b.u.nar) begin
            e.posit = 32'h8000_0000;
            return e;
        end
        if (b.u.zero) return e;
        if (k >= N-2) begin
            mag = '1; e.sat = 1; e.inexact = 1;
        end else if (k <= -(N-1)) begin
            mag = 1; e.sat = 1; e.inexact = 1;
        end else begin
            if (k >= 0) begin repeat (k+1) bits.push_back(1); bits.push_back(0); end
            else begin repeat (-k) bits.push_back(0); bits.push_back(1); end
            for (int i = ES-1; i >= 0; i--) bits.push_back(b.u.exp[i]);
            for (int i = FW-1; i >= 0; i--) bits.push_back(b.u.frac[i]);
            kept = 0;
            for (int i = 0; i < N-1; i++) kept = kept*2 + longint'(bits[i]);
            g = bits[N-1];
            s = b.u.sticky;
            for (int i = N; i < bits.size(); i++) s |= bits[i];
            case (rmode_e'(b.rm))
                RNE:     up = g & (s | kept[0]);
                RTZ:     up = 0;
                RUP:     up = !b.u.sign & (g | s);
                default: up = b.u.sign & (g | s);
            endcase
            kept += longint'(up);
            e.inexact = g | s;
            if (kept > maxv) begin kept = maxv; e.sat = 1; end
            else if (kept == 0) begin kept = 1; e.sat = 1; e.inexact = 1; end
            mag = kept[N-2:0];
        end
        e.posit = {1'b0, mag};
        if (b.u.sign) e.posit = -e.posit;
        return e;
    endfunction

    function automatic beat_t mk(input bit sg, input int k, input logic [1:0] ex, input logic [63:0] fr,
                                 input bit st, input bit z, input bit na, input rmode_e rm);
        beat_t b;
        b.u.sign = sg; b.u.k = k[RS+1:0]; b.u.exp = ex; b.u.frac = fr;
        b.u.sticky = st; b.u.zero = z; b.u.nar = na; b.rm = rm;
        return b;
    endfunction

    function automatic beat_t rnd();
        beat_t b;
        int k = int'($urandom_range(0, 90)) - 45;
        b.u.sign = 1'($urandom);
        b.u.k = k[RS+1:0];
        b.u.exp = 2'($urandom);
        b.u.frac = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) b.u.frac[35:0] = '0;
        b.u.sticky = ($urandom_range(0, 3) == 0);
        b.u.zero = ($urandom_range(0, 15) == 0);
        b.u.nar = ($urandom_range(0, 15) == 0);
        b.rm = 2'($urandom);
        return b;
    endfunction

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send(input beat_t b, input logic has_lit, input logic [N+1:0] lit);
        exp_t e;
        logic acc = 0;
        int tries = 0;
        in_sign = b.u.sign; in_k = b.u.k; in_exp = b.u.exp; in_frac = b.u.frac;
        in_sticky = b.u.sticky; in_zero = b.u.zero; in_nar = b.u.nar; in_rmode = b.rm;
        in_valid = 1;
        while (!acc && tries < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 0;
        check("accept", acc, 1);
        if (acc) begin
            e = model(b);
            e.has_lit = has_lit;
            e.lit = lit;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic latency();
        int n = 1;
        while (n < 10) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            n++;
        end
        check("latency", n, 2);
    endtask

    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
        end
    end

    always @(negedge clk) begin
        if (rst) prev_stall = 0;
        else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_posit", out_posit, prev_posit);
                check("stall_flags", {out_inexact, out_sat}, {prev_inex, prev_sat});
            end
            if (out_valid && out_ready) begin
                check("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    popped++;
                    check("posit", out_posit, mon_e.posit);
                    check("inexact", out_inexact, mon_e.inexact);
                    check("sat", out_sat, mon_e.sat);
                    if (mon_e.has_lit) check("directed", {out_posit, out_inexact, out_sat}, mon_e.lit);
                end
            end
            prev_stall = out_valid & ~out_ready;
            prev_posit = out_posit;
            prev_inex = out_inexact;
            prev_sat = out_sat;
        end
    end

    localparam logic [63:0] TIE = 64'h0000_0010_0000_0000;

    initial begin
        int p0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_posit", out_posit, 0);
        check("rst_flags", {out_inexact, out_sat}, 0);
        @(posedge clk);
        #1;
        rst = 0;

        send(mk(0, 0, 0, 0, 0, 0, 0, RNE), 1, {32'h4000_0000, 2'b00});
        latency();
        drain();

        send(mk(1, 0, 0, 0, 0, 0, 0, RNE), 1, {32'hC000_0000, 2'b00});
        send(mk(0, 0, 0, TIE, 0, 0, 0, RNE), 1, {32'h4000_0000, 2'b10});
        send(mk(0, 0, 0, TIE, 0, 0, 0, RUP), 1, {32'h4000_0001, 2'b10});
        send(mk(0, 0, 0, TIE, 0, 0, 0, RTZ), 1, {32'h4000_0000, 2'b10});
        send(mk(0, 0, 0, TIE, 1, 0, 0, RNE), 1, {32'h4000_0001, 2'b10});
        send(mk(0, 40, 0, 0, 0, 0, 0, RNE), 1, {32'h7FFF_FFFF, 2'b11});
        send(mk(1, 40, 0, 0, 0, 0, 0, RNE), 1, {32'h8000_0001, 2'b11});
        send(mk(0, -40, 0, 0, 0, 0, 0, RNE), 1, {32'h0000_0001, 2'b11});
        send(mk(0, 3, 1, 0, 0, 1, 1, RNE), 1, {32'h8000_0000, 2'b00});
        send(mk(1, 3, 1, 0, 0, 1, 0, RUP), 1, {32'h0000_0000, 2'b00});
        drain();

        p0 = popped;
        fork
            for (int i = 0; i < 5; i++) send(rnd(), 0, '0);
            begin
                rdy_val = 1;
                repeat (2) @(posedge clk);
                rdy_val = 0;
                repeat (4) @(posedge clk);
                rdy_val = 1;
            end
            begin
                saw_low = 0;
                repeat (12) begin
                    @(negedge clk);
                    if (!in_ready) saw_low = 1;
                end
            end
        join
        check("bp_in_ready_low", saw_low, 1);
        drain();
        check("bp_count", popped - p0, 5);

        rdy_rand = 1;
        for (int i = 0; i < 300; i++) send(rnd(), 0, '0);
        rdy_rand = 0;
        rdy_val = 1;
        drain();

        rdy_val = 0;
        @(posedge clk);
        #1;
        send(rnd(), 0, '0);
        send(rnd(), 0, '0);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_posit", out_posit, 0);
        rdy_val = 1;
        @(posedge clk);
        #1;
        send(mk(0, 0, 0, 0, 0, 0, 0, RNE), 1, {32'h4000_0000, 2'b00});
        latency();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
